// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared enums and helpers for the multi-channel waveform generator
package wavegen_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  function automatic int ch_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wavegen_multi_if.sv
// rtl/wavegen_multi_if.sv - control and sample bus of wavegen_multi; amp_shift exists only with WAVEGEN_AMP_SCALE_EN
interface wavegen_multi_if #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8,
  parameter int NCH     = 2,
  parameter int BURST_W = 8
);
  import wavegen_pkg::*;

  localparam int CH_W = ch_sel_w(NCH);

  logic                   en;
  logic                   start;
  logic [BURST_W-1:0]     burst_len;
  logic [D_WIDTH-1:0]     incr;
  logic [1:0]             mode;
  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_ch;
  logic [A_WIDTH-1:0]     cfg_offset;
`ifdef WAVEGEN_AMP_SCALE_EN
  logic [2:0]             amp_shift;
`endif
  logic [NCH*D_WIDTH-1:0] dout;
  logic                   dout_valid;
  logic                   busy;

  modport master (
`ifdef WAVEGEN_AMP_SCALE_EN
    output amp_shift,
`endif
    output en, start, burst_len, incr, mode, cfg_we, cfg_ch, cfg_offset,
    input  dout, dout_valid, busy
  );

  modport slave (
`ifdef WAVEGEN_AMP_SCALE_EN
    input  amp_shift,
`endif
    input  en, start, burst_len, incr, mode, cfg_we, cfg_ch, cfg_offset,
    output dout, dout_valid, busy
  );

endinterface

// File: rtl/wavegen_multi_sine_rom.sv
// rtl/wavegen_multi_sine_rom.sv - synchronous one-read-port sine ROM, offset-binary samples, 1-cycle latency
module sine_rom #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [A_WIDTH-1:0] addr,
  output logic [D_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam int HALF  = 2 ** (A_WIDTH - 1);

  // Bhaskara's rational sine per half period: exact at 0, peak and zero crossings.
  function automatic logic [D_WIDTH-1:0] sine_at(input int a);
    longint mid, pos, u, num, den, mag;
    mid = longint'(1) << (D_WIDTH - 1);
    pos = longint'(a % HALF);
    u   = pos * (longint'(HALF) - pos);
    num = (mid - 1) * 16 * u;
    den = 5 * longint'(HALF) * longint'(HALF) - 4 * u;
    mag = (2 * num + den) / (2 * den);
    return (a >= HALF) ? D_WIDTH'(mid - mag) : D_WIDTH'(mid + mag);
  endfunction

  logic [D_WIDTH-1:0] rom_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    assign rom_tbl[i] = sine_at(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= rom_tbl[addr];
    end
  end

endmodule

// File: rtl/wavegen_multi.sv
// rtl/wavegen_multi.sv - shared-phase multi-channel sine/square/triangle/saw generator with burst mode
// Optional WAVEGEN_AMP_SCALE_EN adds amp_shift scaling around mid-scale and one extra output stage.
module wavegen_multi
  import wavegen_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8,
  parameter int NCH     = 2,
  parameter int BURST_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  wavegen_multi_if.slave bus
);

  function automatic logic [A_WIDTH-1:0] off_rst(input int k);
    return A_WIDTH'((longint'(k) << A_WIDTH) / longint'(NCH));
  endfunction

  state_t               state;
  mode_t                mode_q;
  logic [A_WIDTH-1:0]   phase;
  logic [A_WIDTH-1:0]   offset [NCH];
  logic [BURST_W-1:0]   remaining;
  logic [A_WIDTH:0]     sum;
  logic                 advance;
  logic                 busy_q;
  logic                 valid_q;
  logic [NCH*D_WIDTH-1:0] s1;

  assign sum     = {1'b0, phase} + (A_WIDTH+1)'(bus.incr);
  assign advance = ((state == S_RUN) && bus.en) || (state == S_BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      mode_q    <= MODE_SINE;
      for (int k = 0; k < NCH; k++) offset[k] <= off_rst(k);
    end else begin
      valid_q <= advance;
      if (advance) mode_q <= mode_t'(bus.mode);
      if (bus.cfg_we && (int'(bus.cfg_ch) < NCH)) offset[bus.cfg_ch] <= bus.cfg_offset;
      case (state)
        S_IDLE: begin
          if (bus.start && (bus.burst_len != '0)) begin
            state     <= S_BURST;
            remaining <= bus.burst_len;
            busy_q    <= 1'b1;
          end else if (bus.en) begin
            state  <= S_RUN;
            busy_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.en) begin
            phase <= sum[A_WIDTH-1:0];
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_BURST: begin
          phase <= sum[A_WIDTH-1:0];
          // The carry out of the phase add marks the end of one full period.
          if (sum[A_WIDTH]) begin
            if (remaining == BURST_W'(1)) begin
              state  <= S_IDLE;
              phase  <= '0;
              busy_q <= 1'b0;
            end else begin
              remaining <= remaining - BURST_W'(1);
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [A_WIDTH-1:0] addr;
    logic [A_WIDTH-1:0] tri_v;
    logic [D_WIDTH-1:0] wave;
    logic [D_WIDTH-1:0] wave_q;
    logic [D_WIDTH-1:0] rom_q;

    assign addr  = phase + offset[k];
    assign tri_v = addr[A_WIDTH-1] ? {~addr[A_WIDTH-2:0], 1'b0} : {addr[A_WIDTH-2:0], 1'b0};

    always_comb begin
      wave = '0;
      case (mode_t'(bus.mode))
        MODE_SQUARE: wave = {D_WIDTH{addr[A_WIDTH-1]}};
        MODE_TRI:    wave = tri_v[A_WIDTH-1 -: D_WIDTH];
        MODE_SAW:    wave = addr[A_WIDTH-1 -: D_WIDTH];
        default:     wave = '0;
      endcase
    end

    // Computed waves register alongside the ROM read so every mode has the same latency.
    always_ff @(posedge clk) begin
      if (rst) begin
        wave_q <= '0;
      end else if (advance) begin
        wave_q <= wave;
      end
    end

    sine_rom #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_rom (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .addr (addr),
      .q    (rom_q)
    );

    assign s1[k*D_WIDTH +: D_WIDTH] = (mode_q == MODE_SINE) ? rom_q : wave_q;
  end

`ifdef WAVEGEN_AMP_SCALE_EN
  localparam logic [D_WIDTH-1:0] MID = D_WIDTH'(1 << (D_WIDTH - 1));

  logic [NCH*D_WIDTH-1:0] scaled_flat;
  logic [NCH*D_WIDTH-1:0] s2;
  logic                   valid2;

  for (genvar k = 0; k < NCH; k++) begin : g_amp
    logic signed [D_WIDTH:0] centered;
    logic signed [D_WIDTH:0] scaled;
    assign centered = $signed({1'b0, s1[k*D_WIDTH +: D_WIDTH]}) - $signed({1'b0, MID});
    assign scaled   = (centered >>> bus.amp_shift) + $signed({1'b0, MID});
    assign scaled_flat[k*D_WIDTH +: D_WIDTH] = scaled[D_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2     <= '0;
      valid2 <= 1'b0;
    end else begin
      valid2 <= valid_q;
      if (valid_q) s2 <= scaled_flat;
    end
  end

  assign bus.dout       = s2;
  assign bus.dout_valid = valid2;
`else
  assign bus.dout       = s1;
  assign bus.dout_valid = valid_q;
`endif

  assign bus.busy = busy_q;

endmodule
